sl_receiver: RTL and testbench

- Receive side of the two-wire SL serial link (sl0/sl1), the counterpart of SlTransmitter.
- Deserialises 8/16/32-bit words, checks odd parity, framing and timeouts, and presents each word with a one-cycle valid strobe.
- Sits in the clk domain next to the transmitter. Its outputs are later synchronised into the APB register block as the receive data and status registers.

---
 rtl/sl_pkg.sv | 39 +++
 rtl/sl_input_sync.sv | 28 ++
 rtl/sl_receiver.sv | 188 ++++++++++++++++++
 tb/tb_sl_receiver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// sl_pkg: types and constants shared by the SL link transmitter and receiver.
//   sl_mode_t     - word-length selector (8/16/32 data bits; 2'b11 behaves as 32)
//   sl_rx_state_t - receiver FSM states
//   mode_bits()   - number of data bits for a mode value
//   LINE_IDLE / LINE_STOP - line-pair values for {sl0, sl1}
package sl_pkg;

  typedef enum logic [1:0] {
    MODE8  = 2'b00,
    MODE16 = 2'b01,
    MODE32 = 2'b10
  } sl_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SYMBOL,
    GAP,
    STOP,
    FLUSH,
    STOP_FLUSH
  } sl_rx_state_t;

  localparam logic [1:0] LINE_IDLE = 2'b11;
  localparam logic [1:0] LINE_STOP = 2'b00;

  // Symbol counter saturates here so an over-long word can never wrap back to a legal count.
  localparam logic [5:0] BIT_CNT_MAX = 6'd34;

  function automatic logic [5:0] mode_bits(input logic [1:0] mode);
    logic [5:0] bits;
    case (mode)
      MODE8:   bits = 6'd8;
      MODE16:  bits = 6'd16;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/sl_input_sync.sv
// sl_input_sync: multi-stage synchroniser for the two asynchronous SL lines.
//   clk     - sampling clock
//   reset   - asynchronous active-high reset; all stages reset to the idle pair 2'b11
//   line_i  - raw {sl0, sl1}
//   line_o  - synchronised {sl0, sl1}, SYNC_STAGES cycles behind line_i
module sl_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] line_i,
  output logic [1:0] line_o
);

  logic [2*SYNC_STAGES-1:0] chain_q;

  // Resetting to idle keeps the receiver from seeing a phantom stop symbol after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[2*SYNC_STAGES-3:0], line_i};
    end
  end

  assign line_o = chain_q[2*SYNC_STAGES-1 -: 2];

endmodule

// File: rtl/sl_receiver.sv
// sl_receiver: receive side of the two-wire SL serial link.
//   clk, reset  - clock and asynchronous active-high reset
//   enable      - 0 holds the FSM idle and drops any partial word
//   mode        - word length 00=8, 01=16, 1x=32 bits; latched at the first symbol
//   sl0, sl1    - asynchronous link lines (low sl0 = bit 0, low sl1 = bit 1, both low = stop)
//   data        - last good word, zero-extended, held until the next good word
//   valid       - one-cycle strobe when data updates
//   parity_err  - one-cycle strobe, word rejected on odd-parity failure
//   frame_err   - one-cycle strobe, wrong symbol count or both lines low mid-symbol
//   timeout_err - one-cycle strobe, symbol or gap lasted too long
//   busy        - FSM not idle
module sl_receiver
  import sl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        sl0,
  input  logic        sl1,
  output logic [31:0] data,
  output logic        valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [CNT_WIDTH-1:0] TmoLimit = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [1:0] line;
  logic       is_sym;
  logic       rx_bit;
  logic [5:0] n_bits;

  sl_rx_state_t state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [32:0]          shreg_q, shreg_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic [31:0]          data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 par_q, par_d;
  logic                 frame_q, frame_d;
  logic                 tout_q, tout_d;

  sl_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .line_i({sl0, sl1}),
    .line_o(line)
  );

  // Exactly one line low is a data symbol; the bit value is whichever line stayed high on sl0.
  assign is_sym = line[1] ^ line[0];
  assign rx_bit = line[1];
  assign n_bits = mode_bits(mode_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    par_d     = 1'b0;
    frame_d   = 1'b0;
    tout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_sym) begin
          mode_d    = mode;
          shreg_d   = {32'd0, rx_bit};
          bit_cnt_d = 6'd1;
          state_d   = SYMBOL;
        end else if (line == LINE_STOP) begin
          state_d = STOP_FLUSH;
        end
      end
      SYMBOL: begin
        if (line == LINE_IDLE) begin
          state_d = GAP;
        end else if (line == LINE_STOP) begin
          frame_d = 1'b1;
          state_d = FLUSH;
        end else if (tmo_q == TmoLimit) begin
          tout_d  = 1'b1;
          state_d = FLUSH;
        end
      end
      GAP: begin
        if (is_sym) begin
          // Only the first N+1 symbols are kept; extras just bump the count.
          if (bit_cnt_q < n_bits + 6'd1) begin
            shreg_d = {shreg_q[31:0], rx_bit};
          end
          if (bit_cnt_q != BIT_CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
          state_d = SYMBOL;
        end else if (line == LINE_STOP) begin
          state_d = STOP;
        end else if (tmo_q == TmoLimit) begin
          tout_d  = 1'b1;
          state_d = FLUSH;
        end
      end
      STOP: begin
        if (line == LINE_IDLE) begin
          state_d = IDLE;
          if (bit_cnt_q != n_bits + 6'd1) begin
            frame_d = 1'b1;
          end else if (^shreg_q == 1'b0) begin
            par_d = 1'b1;
          end else begin
            // Upper bits were cleared at word start, so this is already zero-extended.
            data_d  = shreg_q[32:1];
            valid_d = 1'b1;
          end
        end
      end
      FLUSH, STOP_FLUSH: begin
        if (line == LINE_IDLE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      data_d  = data_q;
      valid_d = 1'b0;
      par_d   = 1'b0;
      frame_d = 1'b0;
      tout_d  = 1'b0;
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == SYMBOL || state_q == GAP) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_q     <= 1'b0;
      frame_q   <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_q     <= par_d;
      frame_q   <= frame_d;
      tout_q    <= tout_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign parity_err  = par_q;
  assign frame_err   = frame_q;
  assign timeout_err = tout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sl_receiver.sv
// tb_sl_receiver: self-checking bench for sl_receiver (table vectors, random words, corner cases).
module tb_sl_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        sl0 = 1'b1;
  logic        sl1 = 1'b1;
  logic [31:0] data;
  logic        valid, parity_err, frame_err, timeout_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid, n_par, n_frame, n_tmo;
  logic [3:0] strb;
  logic [3:0] prev_strb = 4'b0;

  always #5 clk = ~clk;

  sl_receiver #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(255),
    .CNT_WIDTH     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .sl0        (sl0),
    .sl1        (sl1),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: counts each strobe, checks exclusivity and one-cycle width.
  always @(negedge clk) begin
    strb = {valid, parity_err, frame_err, timeout_err};
    if (strb != 4'b0) begin
      check("strobe_exclusive", 64'($countones(strb)), 64'd1);
      check("strobe_one_cycle", {60'd0, strb & prev_strb}, 64'd0);
    end
    prev_strb = strb;
    n_valid += int'(valid);
    n_par   += int'(parity_err);
    n_frame += int'(frame_err);
    n_tmo   += int'(timeout_err);
  end

  task automatic clear_counts();
    n_valid = 0;
    n_par   = 0;
    n_frame = 0;
    n_tmo   = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sym(input logic b, input int low, input int gap);
    if (b) sl1 = 1'b0;
    else   sl0 = 1'b0;
    tick(low);
    sl0 = 1'b1;
    sl1 = 1'b1;
    tick(gap);
  endtask

  // Sends nbits data bits MSB first, odd parity (optionally inverted), then stop.
  task automatic send_word(input logic [31:0] w, input int nbits, input bit flip,
                           input int low, input int gap, input int stop_low,
                           input logic [1:0] m_first, input logic [1:0] m_rest,
                           output logic busy_mid);
    logic p;
    p = 1'b1 ^ flip;
    for (int i = 0; i < nbits; i++) p ^= w[i % 32];
    mode = m_first;
    for (int i = nbits - 1; i >= 0; i--) begin
      send_sym(w[i % 32], low, gap);
      if (i == nbits - 1) mode = m_rest;
    end
    send_sym(p, low, gap);
    sl0 = 1'b0;
    sl1 = 1'b0;
    tick(stop_low);
    busy_mid = busy;
    sl0 = 1'b1;
    sl1 = 1'b1;
    tick(6);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] word;
    int          nbits;
    bit          flip;
    int          exp_v;
    int          exp_p;
    int          exp_f;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] ref_data;
  logic        bm;
  logic [1:0]  rm;
  logic [31:0] rw;
  int          rn, rnb, sel, ev, ep, ef, t_k;
  bit          rfl;

  initial begin
    tbl[0] = '{2'b00, 32'h0000_00A5, 8,  1'b0, 1, 0, 0, 32'h0000_00A5};
    tbl[1] = '{2'b10, 32'hDEAD_BEEF, 32, 1'b0, 1, 0, 0, 32'hDEAD_BEEF};
    tbl[2] = '{2'b01, 32'h0000_1234, 16, 1'b1, 0, 1, 0, 32'hDEAD_BEEF};
    tbl[3] = '{2'b00, 32'h0000_0052, 7,  1'b0, 0, 0, 1, 32'hDEAD_BEEF};
    tbl[4] = '{2'b00, 32'h0000_003C, 8,  1'b0, 1, 0, 0, 32'h0000_003C};
    tbl[5] = '{2'b01, 32'h0000_FFFF, 16, 1'b0, 1, 0, 0, 32'h0000_FFFF};
    tbl[6] = '{2'b11, 32'h8000_0001, 32, 1'b0, 1, 0, 0, 32'h8000_0001};
    // 73 symbols in 8-bit mode: a wrapping 6-bit count would land on 9 and accept it.
    tbl[7] = '{2'b00, 32'h1357_9BDF, 72, 1'b0, 0, 0, 1, 32'h8000_0001};

    clear_counts();
    tick(3);
    check("reset_data", {32'd0, data}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_strobes", {60'd0, valid, parity_err, frame_err, timeout_err}, 64'd0);
    reset = 1'b0;
    tick(3);

    foreach (tbl[i]) begin
      clear_counts();
      send_word(tbl[i].word, tbl[i].nbits, tbl[i].flip, 3, 3, 3, tbl[i].mode, tbl[i].mode, bm);
      check($sformatf("vec%0d_valid", i), 64'(n_valid), 64'(tbl[i].exp_v));
      check($sformatf("vec%0d_parity", i), 64'(n_par), 64'(tbl[i].exp_p));
      check($sformatf("vec%0d_frame", i), 64'(n_frame), 64'(tbl[i].exp_f));
      check($sformatf("vec%0d_timeout", i), 64'(n_tmo), 64'd0);
      check($sformatf("vec%0d_data", i), {32'd0, data}, {32'd0, tbl[i].exp_data});
      check($sformatf("vec%0d_busy_mid", i), {63'd0, bm}, 64'd1);
      check($sformatf("vec%0d_busy_end", i), {63'd0, busy}, 64'd0);
    end
    ref_data = tbl[7].exp_data;

    // Random words against a rule-level model.
    for (int r = 0; r < 40; r++) begin
      rm  = 2'($urandom_range(0, 3));
      rn  = (rm == 2'b00) ? 8 : (rm == 2'b01) ? 16 : 32;
      rw  = $urandom;
      sel = $urandom_range(0, 9);
      rnb = (sel == 0) ? rn - 1 : (sel == 1) ? rn + 1 : rn;
      rfl = ($urandom_range(0, 4) == 0);
      ev = 0; ep = 0; ef = 0;
      if (rnb != rn) ef = 1;
      else if (rfl) ep = 1;
      else begin
        ev = 1;
        ref_data = (rn == 32) ? rw : (rw & ((32'd1 << rn) - 32'd1));
      end
      clear_counts();
      send_word(rw, rnb, rfl, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                rm, rm, bm);
      check($sformatf("rnd%0d_valid", r), 64'(n_valid), 64'(ev));
      check($sformatf("rnd%0d_parity", r), 64'(n_par), 64'(ep));
      check($sformatf("rnd%0d_frame", r), 64'(n_frame), 64'(ef));
      check($sformatf("rnd%0d_timeout", r), 64'(n_tmo), 64'd0);
      check($sformatf("rnd%0d_data", r), {32'd0, data}, {32'd0, ref_data});
    end

    // Mode change after the first symbol is ignored for the rest of the word.
    clear_counts();
    send_word(32'h0000_00C3, 8, 1'b0, 2, 2, 2, 2'b00, 2'b10, bm);
    mode = 2'b00;
    check("modechg_valid", 64'(n_valid), 64'd1);
    check("modechg_data", {32'd0, data}, 64'h0000_00C3);
    ref_data = 32'h0000_00C3;

    // Stop held far beyond the timeout, and a 250-cycle gap mid-word: both legal.
    clear_counts();
    send_word(32'h0000_005A, 8, 1'b0, 2, 2, 300, 2'b00, 2'b00, bm);
    check("longstop_valid", 64'(n_valid), 64'd1);
    check("longstop_timeout", 64'(n_tmo), 64'd0);
    check("longstop_data", {32'd0, data}, 64'h0000_005A);
    clear_counts();
    send_word(32'h0000_0066, 8, 1'b0, 2, 250, 2, 2'b00, 2'b00, bm);
    check("longgap_valid", 64'(n_valid), 64'd1);
    check("longgap_timeout", 64'(n_tmo), 64'd0);
    check("longgap_data", {32'd0, data}, 64'h0000_0066);
    ref_data = 32'h0000_0066;

    // Both lines fall while a symbol is active.
    clear_counts();
    sl0 = 1'b0;
    tick(3);
    sl1 = 1'b0;
    tick(3);
    sl0 = 1'b1;
    sl1 = 1'b1;
    tick(6);
    check("bothfall_frame", 64'(n_frame), 64'd1);
    check("bothfall_valid", 64'(n_valid), 64'd0);
    check("bothfall_data", {32'd0, data}, {32'd0, ref_data});
    check("bothfall_busy", {63'd0, busy}, 64'd0);

    // Stop with no word: silently flushed.
    clear_counts();
    sl0 = 1'b0;
    sl1 = 1'b0;
    tick(4);
    sl0 = 1'b1;
    sl1 = 1'b1;
    tick(6);
    check("lonestop_strobes", 64'(n_valid + n_par + n_frame + n_tmo), 64'd0);
    check("lonestop_busy", {63'd0, busy}, 64'd0);

    // Gap timeout: release at edge 0 reaches the FSM as GAP at edge 3 (2 sync + 1 register),
    // the counter hits 255 at edge 258 and the strobe is registered at edge 259.
    clear_counts();
    mode = 2'b00;
    send_sym(1'b1, 2, 0);
    t_k = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (timeout_err && t_k == 0) t_k = k;
    end
    check("gaptmo_cycle", 64'(t_k), 64'd259);
    check("gaptmo_count", 64'(n_tmo), 64'd1);
    check("gaptmo_busy", {63'd0, busy}, 64'd0);
    check("gaptmo_data", {32'd0, data}, {32'd0, ref_data});

    // Symbol held low too long.
    clear_counts();
    sl0 = 1'b0;
    tick(300);
    sl0 = 1'b1;
    tick(6);
    check("symtmo_count", 64'(n_tmo), 64'd1);
    check("symtmo_frame", 64'(n_frame), 64'd0);
    check("symtmo_busy", {63'd0, busy}, 64'd0);

    // Enable dropped mid-word: partial word discarded, activity ignored while disabled.
    clear_counts();
    mode = 2'b00;
    for (int i = 0; i < 4; i++) send_sym(1'b1, 2, 2);
    check("en_busy_before", {63'd0, busy}, 64'd1);
    enable = 1'b0;
    tick(1);
    check("en_busy_drop", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) send_sym(1'b0, 2, 2);
    check("en_busy_ignored", {63'd0, busy}, 64'd0);
    check("en_no_strobes", 64'(n_valid + n_par + n_frame + n_tmo), 64'd0);
    enable = 1'b1;
    tick(2);
    send_word(32'h0000_007E, 8, 1'b0, 2, 2, 2, 2'b00, 2'b00, bm);
    check("en_after_valid", 64'(n_valid), 64'd1);
    check("en_after_data", {32'd0, data}, 64'h0000_007E);

    // Asynchronous reset during bit 5 of a 32-bit word.
    clear_counts();
    mode = 2'b10;
    for (int i = 0; i < 4; i++) send_sym(i[0], 2, 2);
    sl0 = 1'b0;
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_data", {32'd0, data}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_strobes", {60'd0, valid, parity_err, frame_err, timeout_err}, 64'd0);
    @(posedge clk);
    #1;
    sl0 = 1'b1;
    reset = 1'b0;
    tick(3);
    clear_counts();
    send_word(32'h0000_0001, 8, 1'b0, 2, 2, 2, 2'b00, 2'b00, bm);
    check("rst_after_valid", 64'(n_valid), 64'd1);
    check("rst_after_data", {32'd0, data}, 64'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "time limit reached");
  end

endmodule
